// File: rtl/bnn_pe_array_param_if.sv
// Handshake bundle for the binary PE array: one input stream (weights, then
// activations) and one result stream carrying per-row psums and sign bits.
interface bnn_pe_array_param_if #(
    parameter int VEC    = 27,
    parameter int ROWS   = 3,
    parameter int PSUM_W = 8
);
    logic [VEC-1:0]         data_in;
    logic                   in_valid;
    logic                   in_ready;
    logic                   reload_in;
    logic                   out_valid;
    logic                   out_ready;
    logic [ROWS-1:0]        out_sign;
    logic [ROWS*PSUM_W-1:0] out_psum;

    modport master (
        output data_in, in_valid, reload_in, out_ready,
        input  in_ready, out_valid, out_sign, out_psum
    );

    modport slave (
        input  data_in, in_valid, reload_in, out_ready,
        output in_ready, out_valid, out_sign, out_psum
    );
endinterface

// File: rtl/bnn_pe_array_param.sv
// Weight-stationary XNOR-popcount PE array: loads ROWS x COLS weight words, streams
// COLS-word activation windows, and emits one signed psum and sign bit per row.
module bnn_pe_array_param #(
    parameter int VEC    = 27,
    parameter int ROWS   = 3,
    parameter int COLS   = 3,
    parameter int PSUM_W = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    bnn_pe_array_param_if.slave  bus
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    // The psum must hold +/-COLS*VEC without wrapping.
    if ((2 ** (PSUM_W - 1)) <= (COLS * VEC)) begin : g_psum_w_check
        $error("bnn_pe_array_param: PSUM_W too small for COLS*VEC");
    end

    typedef enum logic [1:0] {LOAD_W, LOAD_A, COMP, OUT} state_e;

    state_e             state_q;
    logic [RW-1:0]      row_q;
    logic [CW-1:0]      col_q;
    logic [VEC-1:0]     weight_q [ROWS][COLS];
    logic [VEC-1:0]     act_q    [COLS];
    logic [PSUM_W-1:0]  psum_q   [ROWS];
    logic               in_ready_q;
    logic               out_valid_q;

    logic [PSUM_W-1:0]  ones_d;
    logic [PSUM_W-1:0]  psum_d;

    // Row psum = 2*matches - COLS*VEC; the width check above makes the
    // modular PSUM_W-bit arithmetic exact.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        ones_d = '0;
        for (int c = 0; c < COLS; c++) begin
            ones_d = ones_d + PSUM_W'($countones(~(weight_q[row_q][c] ^ act_q[c])));
        end
        psum_d = (ones_d << 1) - PSUM_W'(COLS * VEC);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= LOAD_W;
            row_q       <= '0;
            col_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            // NOTE: the storage arrays are cleared on reset on purpose, so a stale
            // window can never leak into the first result after reset.
            for (int r = 0; r < ROWS; r++) begin
                psum_q[r] <= '0;
                for (int c = 0; c < COLS; c++) begin
                    weight_q[r][c] <= '0;
                end
            end
            for (int c = 0; c < COLS; c++) begin
                act_q[c] <= '0;
            end
        end else begin
            case (state_q)
                LOAD_W: begin
                    if (bus.in_valid) begin
                        weight_q[row_q][col_q] <= bus.data_in;
                        if (col_q == COL_LAST) begin
                            col_q <= '0;
                            if (row_q == ROW_LAST) begin
                                row_q   <= '0;
                                state_q <= LOAD_A;
                            end else begin
                                row_q <= row_q + 1'b1;
                            end
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                LOAD_A: begin
                    if (bus.in_valid) begin
                        act_q[col_q] <= bus.data_in;
                        if (col_q == COL_LAST) begin
                            col_q      <= '0;
                            row_q      <= '0;
                            in_ready_q <= 1'b0;
                            state_q    <= COMP;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                COMP: begin
                    psum_q[row_q] <= psum_d;
                    if (row_q == ROW_LAST) begin
                        row_q       <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end else begin
                        row_q <= row_q + 1'b1;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        col_q       <= '0;
                        row_q       <= '0;
                        state_q     <= bus.reload_in ? LOAD_W : LOAD_A;
                    end
                end
                default: state_q <= LOAD_W;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;

    for (genvar r = 0; r < ROWS; r++) begin : g_out
        assign bus.out_psum[r*PSUM_W +: PSUM_W] = psum_q[r];
        assign bus.out_sign[r]                  = psum_q[r][PSUM_W-1];
    end
endmodule

// File: tb/tb_bnn_pe_array_param.sv
// Directed bench for bnn_pe_array_param at default parameters (27-bit words, 3x3, 8-bit psums).
module tb_bnn_pe_array_param;
    localparam logic [26:0] MASK = 27'h7FFFFFF;
    localparam logic [26:0] M13  = 27'h0001FFF;

    logic clk;
    logic rst;
    int   passed;
    int   total;

    bnn_pe_array_param_if #(.VEC(27), .ROWS(3), .PSUM_W(8)) bus ();

    bnn_pe_array_param #(.VEC(27), .ROWS(3), .COLS(3), .PSUM_W(8)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0][26:0] act_a;

    // Present one word and return just after the edge that accepts it.
    task automatic send_word(input logic [26:0] w);
        bit ok;
        ok = 0;
        @(negedge clk);
        bus.data_in  = w;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            total++;
            $display("FAIL send_word timeout: in_ready=%b required 1", bus.in_ready);
        end
    endtask

    task automatic load_weights(input logic [8:0][26:0] w, input bit gaps);
        for (int k = 0; k < 9; k++) begin
            send_word(w[k]);
            if (gaps) begin
                bus.in_valid = 1'b0;
                repeat (2) @(negedge clk);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic load_acts(input logic [2:0][26:0] a);
        for (int j = 0; j < 3; j++) send_word(a[j]);
        bus.in_valid = 1'b0;
    endtask

    // Cycles counted from the accepting edge; lat=-1 on timeout.
    task automatic wait_result(output logic [23:0] psum, output logic [2:0] sign, output int lat);
        lat  = -1;
        psum = '0;
        sign = '0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                lat  = n;
                psum = bus.out_psum;
                sign = bus.out_sign;
                break;
            end
        end
    endtask

    task automatic test_reset;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else passed++;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else passed++;
        total++; if (bus.out_psum !== 24'h000000) $display("FAIL reset_psum: got %h want 000000", bus.out_psum); else passed++;
        total++; if (bus.out_sign !== 3'b000) $display("FAIL reset_sign: got %b want 000", bus.out_sign); else passed++;
    endtask

    task automatic test_zero;
        logic [23:0] p; logic [2:0] s; int lat;
        bus.reload_in = 1'b1;
        load_weights('0, 1'b0);
        load_acts('0);
        wait_result(p, s, lat);
        total++; if (lat !== 4) $display("FAIL zero_latency: got %0d want 4", lat); else passed++;
        total++; if (p !== 24'h515151) $display("FAIL zero_psum: got %h want 515151", p); else passed++;
        total++; if (s !== 3'b000) $display("FAIL zero_sign: got %b want 000", s); else passed++;
        @(negedge clk);
        total++; if (bus.out_valid !== 1'b0) $display("FAIL zero_valid_drop: got %b want 0", bus.out_valid); else passed++;
        total++; if (bus.out_psum !== 24'h515151) $display("FAIL zero_psum_hold: got %h want 515151", bus.out_psum); else passed++;
    endtask

    task automatic test_ones_weights;
        logic [8:0][26:0] w; logic [23:0] p; logic [2:0] s; int lat;
        for (int k = 0; k < 9; k++) w[k] = MASK;
        bus.reload_in = 1'b0;
        load_weights(w, 1'b1);
        load_acts('0);
        wait_result(p, s, lat);
        total++; if (lat !== 4) $display("FAIL ones_latency: got %0d want 4", lat); else passed++;
        total++; if (p !== 24'hAFAFAF) $display("FAIL ones_psum: got %h want afafaf", p); else passed++;
        total++; if (s !== 3'b111) $display("FAIL ones_sign: got %b want 111", s); else passed++;
        @(negedge clk);
    endtask

    task automatic test_mixed;
        logic [8:0][26:0] w; logic [23:0] p; logic [2:0] s; int lat;
        // Handshake above used reload_in=0; reload again via a dummy window first.
        load_acts('0);
        bus.reload_in = 1'b1;
        wait_result(p, s, lat);
        total++; if (p !== 24'hAFAFAF) $display("FAIL reuse_ones_psum: got %h want afafaf", p); else passed++;
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            w[c]     = act_a[c];
            w[3 + c] = ~act_a[c] & MASK;
            w[6 + c] = act_a[c] ^ M13;
        end
        bus.reload_in = 1'b0;
        load_weights(w, 1'b0);
        load_acts(act_a);
        wait_result(p, s, lat);
        total++; if (lat !== 4) $display("FAIL mixed_latency: got %0d want 4", lat); else passed++;
        total++; if (p !== 24'h03AF51) $display("FAIL mixed_psum: got %h want 03af51", p); else passed++;
        total++; if (s !== 3'b010) $display("FAIL mixed_sign: got %b want 010", s); else passed++;
        @(negedge clk);
    endtask

    task automatic test_reuse_backpressure;
        logic [2:0][26:0] a; logic [23:0] p; logic [2:0] s; int lat;
        for (int c = 0; c < 3; c++) a[c] = ~act_a[c] & MASK;
        bus.out_ready = 1'b0;
        bus.reload_in = 1'b1;
        send_word(a[0]);
        send_word(a[1]);
        total++; if (bus.in_ready !== 1'b1) $display("FAIL reuse_ready_after2: got %b want 1", bus.in_ready); else passed++;
        send_word(a[2]);
        bus.in_valid = 1'b0;
        total++; if (bus.in_ready !== 1'b0) $display("FAIL reuse_ready_after3: got %b want 0", bus.in_ready); else passed++;
        wait_result(p, s, lat);
        total++; if (lat !== 4) $display("FAIL reuse_latency: got %0d want 4", lat); else passed++;
        total++; if (p !== 24'hFD51AF) $display("FAIL reuse_psum: got %h want fd51af", p); else passed++;
        total++; if (s !== 3'b101) $display("FAIL reuse_sign: got %b want 101", s); else passed++;
        bus.in_valid = 1'b1;
        bus.data_in  = MASK;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (bus.out_valid !== 1'b1) $display("FAIL stall_valid[%0d]: got %b want 1", i, bus.out_valid); else passed++;
            total++; if (bus.out_psum !== 24'hFD51AF) $display("FAIL stall_psum[%0d]: got %h want fd51af", i, bus.out_psum); else passed++;
            total++; if (bus.in_ready !== 1'b0) $display("FAIL stall_in_ready[%0d]: got %b want 0", i, bus.in_ready); else passed++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        total++; if (bus.out_valid !== 1'b0) $display("FAIL stall_release: got %b want 0", bus.out_valid); else passed++;
    endtask

    task automatic test_reset_midload;
        logic [8:0][26:0] w; logic [2:0][26:0] a; logic [23:0] p; logic [2:0] s; int lat;
        for (int k = 0; k < 5; k++) send_word(MASK);
        // Reset edge coincides with a presented word; reset must win.
        @(negedge clk);
        bus.data_in  = MASK;
        bus.in_valid = 1'b1;
        rst          = 1'b1;
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b want 0", bus.out_valid); else passed++;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %b want 1", bus.in_ready); else passed++;
        total++; if (bus.out_psum !== 24'h000000) $display("FAIL midrst_psum: got %h want 000000", bus.out_psum); else passed++;
        for (int c = 0; c < 3; c++) begin
            w[c]     = '0;
            w[3 + c] = MASK;
            w[6 + c] = '0;
            a[c]     = MASK;
        end
        bus.reload_in = 1'b1;
        load_weights(w, 1'b0);
        load_acts(a);
        wait_result(p, s, lat);
        total++; if (lat !== 4) $display("FAIL midrst_latency: got %0d want 4", lat); else passed++;
        total++; if (p !== 24'hAF51AF) $display("FAIL midrst_result: got %h want af51af", p); else passed++;
        total++; if (s !== 3'b101) $display("FAIL midrst_sign: got %b want 101", s); else passed++;
        @(negedge clk);
    endtask

    initial begin
        passed        = 0;
        total         = 0;
        act_a[0]      = 27'h1234567;
        act_a[1]      = 27'h7654321;
        act_a[2]      = 27'h0ABCDEF;
        rst           = 1'b1;
        bus.data_in   = '0;
        bus.in_valid  = 1'b0;
        bus.reload_in = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_zero();
        test_ones_weights();
        test_mixed();
        test_reuse_backpressure();
        test_reset_midload();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
